// File: rtl/mux4_scan_sequencer.sv
// Scan sequencer for a 4x1 mux: walks the selects over channels 0..3, samples y after a dwell,
// and hands the packed 4-bit word downstream on valid/ready. Optional MUX_SCAN_PARITY_EN adds sample_parity.
module mux4_scan_sequencer #(
  parameter int DWELL_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  output logic       s0,
  output logic       s1,
  input  logic       y,
  output logic [3:0] sample_data,
  output logic       sample_valid,
  input  logic       sample_ready,
  output logic       busy,
  output logic       overrun
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       sample_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DWELL_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [1:0]       channel, channel_next;
  logic [3:0]       data_next;
  logic             valid_next;

  // Selects come straight from the channel register, so they only move at advance edges.
  assign s0   = channel[1];
  assign s1   = channel[0];
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      channel      <= 2'd0;
      sample_data  <= 4'd0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      channel      <= channel_next;
      sample_data  <= data_next;
      sample_valid <= valid_next;
      overrun      <= start && (state != IDLE);
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    channel_next = channel;
    data_next    = sample_data;
    valid_next   = sample_valid;
    case (state)
      IDLE: begin
        channel_next = 2'd0;
        count_next   = '0;
        if (start) state_next = DWELL;
      end
      DWELL: begin
        if (count == LAST_COUNT) begin
          count_next         = '0;
          data_next[channel] = y;
          if (channel != 2'd3) begin
            channel_next = channel + 2'd1;
          end else begin
            state_next = OUTPUT;
            valid_next = 1'b1;
          end
        end else begin
          count_next = count + 1'b1;
        end
      end
      OUTPUT: begin
        // Word and channel-3 selects hold until the consumer takes the word.
        if (sample_valid && sample_ready) begin
          valid_next   = 1'b0;
          channel_next = 2'd0;
          count_next   = '0;
          state_next   = cont ? DWELL : IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        channel_next = 2'd0;
        count_next   = '0;
        valid_next   = 1'b0;
      end
    endcase
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_parity <= 1'b0;
    else        sample_parity <= ^data_next;
  end
`endif

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
// Directed self-checking bench for mux4_scan_sequencer with a behavioural 4x1 mux driving y.
module tb_mux4_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       s0;
  logic       s1;
  logic       y;
  logic [3:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       busy;
  logic       overrun;
`ifdef MUX_SCAN_PARITY_EN
  logic       sample_parity;
`endif
  logic [3:0] mux_in;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_scan_sequencer #(.DWELL_CYCLES(2), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cont         (cont),
    .s0           (s0),
    .s1           (s1),
    .y            (y),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .sample_parity(sample_parity)
`endif
  );

  // Channel k selects {s0,s1} == k, so the mux is just an index into mux_in.
  assign y = mux_in[{s0, s1}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({s0, s1} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_sel: got %b want 00", {s0, s1}); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", sample_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (sample_data !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %b want 0000", sample_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single_scan();
    mux_in = 4'b0101; sample_ready = 1'b1; cont = 1'b0;
    pulse_start();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_overrun: got %b want 0", overrun); end
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++; if ({s0, s1} !== 2'(k)) begin n_fail++; $display("[TB] FAIL single_sel ch%0d: got %b want %b", k, {s0, s1}, 2'(k)); end
        n_checks++; if (busy !== 1'b1 || sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_valid ch%0d: got %b%b want 10", k, busy, sample_valid); end
        step(1);
      end
    end
    n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b want 1", sample_valid); end
    n_checks++; if (sample_data !== 4'b0101) begin n_fail++; $display("[TB] FAIL single_data: got %b want 0101", sample_data); end
    n_checks++; if ({s0, s1} !== 2'b11) begin n_fail++; $display("[TB] FAIL single_out_sel: got %b want 11", {s0, s1}); end
    step(1);
    n_checks++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle: valid/busy got %b%b want 00", sample_valid, busy); end
    n_checks++; if ({s0, s1} !== 2'b00) begin n_fail++; $display("[TB] FAIL single_idle_sel: got %b want 00", {s0, s1}); end
  endtask

  task automatic test_backpressure();
    mux_in = 4'b1001; sample_ready = 1'b0; cont = 1'b0;
    pulse_start();
    step(8);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (sample_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid c%0d: valid/busy got %b%b want 11", i, sample_valid, busy); end
      n_checks++; if (sample_data !== 4'b1001) begin n_fail++; $display("[TB] FAIL bp_hold_data c%0d: got %b want 1001", i, sample_data); end
      n_checks++; if ({s0, s1} !== 2'b11) begin n_fail++; $display("[TB] FAIL bp_hold_sel c%0d: got %b want 11", i, {s0, s1}); end
      step(1);
    end
    sample_ready = 1'b1;
    step(1);
    n_checks++; if (sample_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release: valid/busy got %b%b want 00", sample_valid, busy); end
  endtask

  task automatic test_overrun();
    mux_in = 4'b0110; sample_ready = 1'b1; cont = 1'b0;
    pulse_start();
    step(2);
    n_checks++; if ({s0, s1} !== 2'b01) begin n_fail++; $display("[TB] FAIL ovr_pre_sel: got %b want 01", {s0, s1}); end
    pulse_start();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_pulse: got %b want 1", overrun); end
    n_checks++; if ({s0, s1} !== 2'b01) begin n_fail++; $display("[TB] FAIL ovr_sel_kept: got %b want 01", {s0, s1}); end
    step(1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_one_cycle: got %b want 0", overrun); end
    step(4);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 4'b0110) begin n_fail++; $display("[TB] FAIL ovr_word: valid %b data %b want 1 0110", sample_valid, sample_data); end
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_idle: got %b want 0", busy); end
  endtask

  task automatic test_continuous();
    mux_in = 4'b1111; sample_ready = 1'b1; cont = 1'b1;
    pulse_start();
    step(8);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 4'hF) begin n_fail++; $display("[TB] FAIL cont_word1: valid %b data %h want 1 F", sample_valid, sample_data); end
    mux_in = 4'b0010;
    step(1);
    cont = 1'b0;
    n_checks++; if (sample_valid !== 1'b0 || busy !== 1'b1 || {s0, s1} !== 2'b00) begin n_fail++; $display("[TB] FAIL cont_restart: valid %b busy %b sel %b want 0 1 00", sample_valid, busy, {s0, s1}); end
    step(7);
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_early: got %b want 0", sample_valid); end
    step(1);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 4'h2) begin n_fail++; $display("[TB] FAIL cont_word2: valid %b data %h want 1 2", sample_valid, sample_data); end
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL cont_stop: got %b want 0", busy); end
  endtask

  task automatic test_reset_midscan();
    mux_in = 4'b1010; sample_ready = 1'b1; cont = 1'b0;
    pulse_start();
    step(5);
    n_checks++; if ({s0, s1} !== 2'b10) begin n_fail++; $display("[TB] FAIL mid_pre_sel: got %b want 10", {s0, s1}); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({s0, s1} !== 2'b00 || busy !== 1'b0 || sample_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset: sel %b busy %b valid %b want 00 0 0", {s0, s1}, busy, sample_valid); end
    n_checks++; if (sample_data !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_reset_data: got %b want 0000", sample_data); end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    mux_in = 4'b0111;
    pulse_start();
    n_checks++; if ({s0, s1} !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_restart_sel: got %b want 00", {s0, s1}); end
    step(8);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 4'b0111) begin n_fail++; $display("[TB] FAIL mid_word: valid %b data %b want 1 0111", sample_valid, sample_data); end
`ifdef MUX_SCAN_PARITY_EN
    n_checks++; if (sample_parity !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_parity: got %b want 1", sample_parity); end
`endif
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; cont = 1'b0; sample_ready = 1'b0; mux_in = 4'd0;
    test_reset();
    test_single_scan();
    test_backpressure();
    test_overrun();
    test_continuous();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
